// File: rtl/bidirectional_piso_serializer.sv
// Parallel-in, serial-out shifter with valid/ready load and per-word
// shift direction (0: MSB first, 1: LSB first); gapless word reload.
module bidirectional_piso_serializer #(
  parameter int SIZE = 8
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [SIZE-1:0] din,
  input  logic            mode,
  input  logic            ser_ready,
  output logic            dout,
  output logic            dout_valid,
  output logic            last,
  output logic            busy
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] sreg_q, sreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;

  logic in_shift;
  logic last_bit;
  logic load_fire;
  logic advance;

  assign in_shift  = (state_q == SHIFT);
  assign last_bit  = in_shift && (cnt_q == CNT_LAST);
  assign load_ready = !in_shift || (last_bit && ser_ready);
  assign load_fire = load_valid && load_ready;
  // A reload on the final bit takes priority over the plain advance
  assign advance   = in_shift && ser_ready && !load_fire;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (1'b1)
      load_fire: begin
        state_d = SHIFT;
        sreg_d  = din;
        mode_d  = mode;
        cnt_d   = '0;
      end
      advance: begin
        if (mode_q) begin
          sreg_d = {1'b0, sreg_q[SIZE-1:1]};
        end else begin
          sreg_d = {sreg_q[SIZE-2:0], 1'b0};
        end
        if (last_bit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign dout       = in_shift &&
                      (mode_q ? sreg_q[0] : sreg_q[SIZE-1]);
  assign dout_valid = in_shift;
  assign busy       = in_shift;
  assign last       = last_bit;

endmodule

// File: tb/tb_bidirectional_piso_serializer.sv
// Scoreboard bench for bidirectional_piso_serializer: table of words
// plus reset, stall, back-to-back and ignored-load sequences.
module tb_bidirectional_piso_serializer;

  localparam int SIZE = 8;

  logic            clock;
  logic            rst;
  logic            load_valid;
  logic            load_ready;
  logic [SIZE-1:0] din;
  logic            mode;
  logic            ser_ready;
  logic            dout;
  logic            dout_valid;
  logic            last;
  logic            busy;

  bidirectional_piso_serializer #(.SIZE(SIZE)) dut (
    .clock      (clock),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .din        (din),
    .mode       (mode),
    .ser_ready  (ser_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .last       (last),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic            b;
    logic            lst;
    logic            md;
    logic [SIZE-1:0] word;
  } exp_bit_t;

  typedef struct {
    logic [SIZE-1:0] d;
    logic            m;
    logic [SIZE-1:0] ser;
    bit              rnd;
  } vec_t;

  exp_bit_t        q[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  int              acc_cnt  = 0;
  int              pop_cnt  = 0;
  int              vcnt     = 0;
  int              run      = 0;
  int              max_run  = 0;
  int              last_runs[$];
  logic [SIZE-1:0] pend_ser;
  logic [SIZE-1:0] sipo;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Scoreboard monitor: inputs change at posedge+1, so the negedge
  // sees exactly what the next posedge will act on.
  always @(negedge clock) begin
    logic     exp_rdy;
    exp_bit_t e;
    if (!rst) begin
      q.delete();
      run = 0;
    end else begin
      exp_rdy = (q.size() == 0) || (q.size() == 1 && ser_ready);
      chk("load_ready", load_ready, exp_rdy);
      if (dout_valid) vcnt++;
      if (dout_valid) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      if (q.size() == 0) begin
        chk("idle_valid", dout_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_dout", dout, 0);
        chk("idle_last", last, 0);
      end else begin
        e = q[0];
        chk("dout_valid", dout_valid, 1);
        chk("busy", busy, 1);
        chk("dout", dout, e.b);
        chk("last", last, e.lst);
        if (ser_ready) begin
          if (e.md) sipo = {dout, sipo[SIZE-1:1]};
          else sipo = {sipo[SIZE-2:0], dout};
          void'(q.pop_front());
          pop_cnt++;
          if (e.lst) begin
            last_runs.push_back(run);
            chk("sipo_rebuild", sipo, e.word);
          end
        end
      end
      if (load_valid && exp_rdy) begin
        for (int i = 0; i < SIZE; i++) begin
          e.b    = pend_ser[SIZE-1-i];
          e.lst  = (i == SIZE - 1);
          e.md   = mode;
          e.word = din;
          q.push_back(e);
        end
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [SIZE-1:0] d, input logic m,
                      input logic [SIZE-1:0] ser);
    int start;
    bit ok;
    din        = d;
    mode       = m;
    pend_ser   = ser;
    load_valid = 1'b1;
    start      = acc_cnt;
    ok         = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      #1;
      if (acc_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("load_accept");
  endtask

  task automatic drain(input bit rnd);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      ser_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clock);
      #1;
    end
    ser_ready = 1'b1;
    if (!ok) fail_now("drain");
  endtask

  task automatic wait_pops(input int n);
    int start;
    bit ok;
    start = pop_cnt;
    ok    = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (pop_cnt - start >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
    if (!ok) fail_now("wait_pops");
  endtask

  vec_t vecs[$];

  initial begin
    int v0;
    vecs = '{
      '{8'hB4, 1'b0, 8'b10110100, 1'b0},
      '{8'hB4, 1'b1, 8'b00101101, 1'b0},
      '{8'h0F, 1'b1, 8'b11110000, 1'b0},
      '{8'h12, 1'b0, 8'b00010010, 1'b0},
      '{8'h12, 1'b1, 8'b01001000, 1'b1},
      '{8'hB4, 1'b0, 8'b10110100, 1'b1}
    };
    rst        = 1'b0;
    load_valid = 1'b0;
    din        = '0;
    mode       = 1'b0;
    ser_ready  = 1'b1;
    pend_ser   = '0;
    sipo       = '0;
    #12;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_last", last, 0);
    chk("rst_busy", busy, 0);
    @(posedge clock);
    #1 rst = 1'b1;
    @(negedge clock);
    #1 chk("post_rst_ready", load_ready, 1);
    @(posedge clock);
    #1;

    foreach (vecs[k]) begin
      send(vecs[k].d, vecs[k].m, vecs[k].ser);
      load_valid = 1'b0;
      drain(vecs[k].rnd);
      repeat (2) @(posedge clock);
      #1;
    end

    // Reset mid-word: bits already queued must never appear
    send(8'hA5, 1'b0, 8'b10100101);
    load_valid = 1'b0;
    wait_pops(3);
    #2 rst = 1'b0;
    #1;
    chk("midrst_dout", dout, 0);
    chk("midrst_valid", dout_valid, 0);
    chk("midrst_last", last, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clock);
    #2 rst = 1'b1;
    @(negedge clock);
    #1 chk("midrst_ready", load_ready, 1);
    repeat (4) @(posedge clock);
    #1;

    // Stall after bit 2 for three cycles
    v0 = vcnt;
    send(8'hF0, 1'b0, 8'b11110000);
    load_valid = 1'b0;
    wait_pops(2);
    ser_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 ser_ready = 1'b1;
    drain(1'b0);
    chk("stall_valid_cycles", vcnt - v0, 11);
    repeat (2) @(posedge clock);
    #1;

    // Back-to-back, load_valid held across the word boundary
    v0      = vcnt;
    max_run = 0;
    last_runs.delete();
    send(8'h81, 1'b0, 8'b10000001);
    send(8'h7E, 1'b0, 8'b01111110);
    load_valid = 1'b0;
    drain(1'b0);
    chk("b2b_valid_cycles", vcnt - v0, 16);
    chk("b2b_run", max_run, 16);
    chk("b2b_nlast", last_runs.size(), 2);
    if (last_runs.size() == 2) begin
      chk("b2b_last1", last_runs[0], 8);
      chk("b2b_last2", last_runs[1], 16);
    end
    repeat (2) @(posedge clock);
    #1;

    // Load request mid-word is ignored
    send(8'h00, 1'b0, 8'b00000000);
    load_valid = 1'b0;
    wait_pops(4);
    din        = 8'hFF;
    load_valid = 1'b1;
    chk("ign_ready", load_ready, 0);
    @(posedge clock);
    #1 load_valid = 1'b0;
    drain(1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("final_queue", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
